// File: rtl/channel_in_tile_acc_pkg.sv
// Shared types and constants for the channel-in tile accumulator.
// Optional saturation is enabled by defining CHANNEL_TILE_ACC_SAT_EN.
`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 16
`endif
`ifndef PICTURE_NUM
`define PICTURE_NUM 8
`endif

package channel_in_tile_acc_pkg;

    localparam int PICTURE_NUM_D = `PICTURE_NUM;
    localparam int LANE_W_D      = 2 * `WIDTH_DATA_OUT;
    localparam int DEPTH_D       = 64;
    localparam int CNT_W_D       = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC,
        ST_DONE
    } state_t;

`ifdef CHANNEL_TILE_ACC_SAT_EN
    localparam logic [LANE_W_D-1:0] SAT_MAX = {1'b0, {(LANE_W_D-1){1'b1}}};
    localparam logic [LANE_W_D-1:0] SAT_MIN = {1'b1, {(LANE_W_D-1){1'b0}}};
`endif

endpackage

// File: rtl/channel_in_tile_acc_lane.sv
// One signed lane adder: wraps by default, saturates when
// CHANNEL_TILE_ACC_SAT_EN is defined.
module tile_acc_lane
    import channel_in_tile_acc_pkg::*;
#(
    parameter int LANE_W = LANE_W_D
) (
    input  logic [LANE_W-1:0] acc,
    input  logic [LANE_W-1:0] addend,
    output logic [LANE_W-1:0] sum
);

`ifdef CHANNEL_TILE_ACC_SAT_EN
    logic [LANE_W:0] wide;

    assign wide = {acc[LANE_W-1], acc} + {addend[LANE_W-1], addend};

    // Top two bits disagree only on signed overflow.
    always_comb begin
        sum = wide[LANE_W-1:0];
        unique case (wide[LANE_W:LANE_W-1])
            2'b01:   sum = LANE_W'(SAT_MAX);
            2'b10:   sum = LANE_W'(SAT_MIN);
            default: sum = wide[LANE_W-1:0];
        endcase
    end
`else
    assign sum = acc + addend;
`endif

endmodule

// File: rtl/channel_in_tile_acc.sv
// Accumulates reduced partial sums across channel-in tiles per position.
// Build option: CHANNEL_TILE_ACC_SAT_EN selects saturating lane adds.
module channel_in_tile_acc
    import channel_in_tile_acc_pkg::*;
#(
    parameter int PICTURE_NUM = PICTURE_NUM_D,
    parameter int LANE_W      = LANE_W_D,
    parameter int DEPTH       = DEPTH_D,
    parameter int CNT_W       = CNT_W_D
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [CNT_W-1:0]              tile_num,
    input  logic [CNT_W-1:0]              pos_num,
    input  logic                          in_valid,
    input  logic [PICTURE_NUM*LANE_W-1:0] data_in,
    output logic                          busy,
    output logic                          out_valid,
    output logic [PICTURE_NUM*LANE_W-1:0] data_out,
    output logic                          done
);

    localparam int AW = $clog2(DEPTH);
    localparam int VW = PICTURE_NUM * LANE_W;

    state_t           state;
    logic [CNT_W-1:0] tile;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] tile_last;
    logic [CNT_W-1:0] pos_last;

    logic [VW-1:0]    mem [DEPTH];
    logic [VW-1:0]    acc_rd;
    logic [VW-1:0]    sum;
    logic [AW-1:0]    addr;
    logic             beat;
    logic             last_tile;
    logic             last_pos;

    assign addr      = pos[AW-1:0];
    assign beat      = (state == ST_ACC) && in_valid;
    assign last_tile = (tile == tile_last);
    assign last_pos  = (pos == pos_last);

    // Tile 0 never reads the RAM, so stale contents are harmless.
    assign acc_rd = (tile == '0) ? '0 : mem[addr];

    for (genvar i = 0; i < PICTURE_NUM; i++) begin : g_lane
        tile_acc_lane #(
            .LANE_W (LANE_W)
        ) u_lane (
            .acc    (acc_rd[i*LANE_W +: LANE_W]),
            .addend (data_in[i*LANE_W +: LANE_W]),
            .sum    (sum[i*LANE_W +: LANE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (beat && !last_tile) begin
            mem[addr] <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tile      <= '0;
            pos       <= '0;
            tile_last <= '0;
            pos_last  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            data_out  <= '0;
            done      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            done      <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Zero or oversized counts are clamped so a pass always ends.
                        tile_last <= (tile_num == '0) ? '0 : tile_num - 1'b1;
                        if (pos_num == '0) begin
                            pos_last <= '0;
                        end else if (pos_num > CNT_W'(DEPTH)) begin
                            pos_last <= CNT_W'(DEPTH - 1);
                        end else begin
                            pos_last <= pos_num - 1'b1;
                        end
                        tile  <= '0;
                        pos   <= '0;
                        busy  <= 1'b1;
                        state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        if (last_tile) begin
                            data_out  <= sum;
                            out_valid <= 1'b1;
                        end
                        if (last_pos) begin
                            pos <= '0;
                            if (last_tile) begin
                                state <= ST_DONE;
                            end else begin
                                tile <= tile + 1'b1;
                            end
                        end else begin
                            pos <= pos + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
